// File: rtl/seg_pkg.sv
// seg_pkg: segment patterns ({g,f,e,d,c,b,a}, active-low) and nibble width for the scan driver.
// Latency: n/a (constants only); no backpressure.
package seg_pkg;
    localparam int DIGIT_W = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;
endpackage

// File: rtl/seg_decoder.sv
// seg_decoder: nibble to active-low segment pattern; 10..15 become letters or blank.
// Latency: combinational; no backpressure.
module seg_decoder
    import seg_pkg::*;
(
    input  logic [DIGIT_W-1:0] nibble,
    input  logic               hex_mode,
    input  logic               blank,
    output logic [6:0]         seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'h0:    seg = SEG_0;
                4'h1:    seg = SEG_1;
                4'h2:    seg = SEG_2;
                4'h3:    seg = SEG_3;
                4'h4:    seg = SEG_4;
                4'h5:    seg = SEG_5;
                4'h6:    seg = SEG_6;
                4'h7:    seg = SEG_7;
                4'h8:    seg = SEG_8;
                4'h9:    seg = SEG_9;
                4'hA:    seg = hex_mode ? SEG_A : SEG_BLANK;
                4'hB:    seg = hex_mode ? SEG_B : SEG_BLANK;
                4'hC:    seg = hex_mode ? SEG_C : SEG_BLANK;
                4'hD:    seg = hex_mode ? SEG_D : SEG_BLANK;
                4'hE:    seg = hex_mode ? SEG_E : SEG_BLANK;
                4'hF:    seg = hex_mode ? SEG_F : SEG_BLANK;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed seven-segment bank driver with frame-coherent capture, LZ blanking and anode guard.
// Latency: outputs registered one cycle behind scan state; no backpressure (free-running, inputs sampled once per frame).
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD       = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic                          hex_mode,
    input  logic                          lz_blank,
    input  logic                          blank_all,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [NUM_DIGITS-1:0]         an,
    output logic                          frame_tick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GUARD_P    = PW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]                   presc;
    logic [IW-1:0]                   idx;
    logic [DIGIT_W*NUM_DIGITS-1:0]   value_sh;
    logic [NUM_DIGITS-1:0]           dp_sh;
    logic                            hex_sh;
    logic                            lz_sh;

    logic                            slot_end;
    logic                            frame_end;
    logic                            guard;
    logic [DIGIT_W-1:0]              nib;
    logic [NUM_DIGITS-1:0]           upper_zero;
    logic                            suppress;
    logic [6:0]                      seg_pat;
    logic [NUM_DIGITS-1:0]           an_pat;

    assign slot_end  = (presc == PRESC_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    assign guard     = (presc < GUARD_P);

    // upper_zero[i]: nibble i and every nibble above it are zero in the shadow copy
    always_comb begin
        logic run;
        run        = 1'b1;
        upper_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run           = run && (value_sh[i*DIGIT_W +: DIGIT_W] == '0);
            upper_zero[i] = run;
        end
    end

    always_comb begin
        nib      = value_sh[int'(idx)*DIGIT_W +: DIGIT_W];
        suppress = lz_sh && (idx != '0) && upper_zero[idx];
        an_pat   = '1;
        if (!guard) begin
            an_pat[idx] = 1'b0;
        end
    end

    seg_decoder u_dec (
        .nibble   (nib),
        .hex_mode (hex_sh),
        .blank    (suppress),
        .seg      (seg_pat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            idx        <= '0;
            value_sh   <= '0;
            dp_sh      <= '0;
            hex_sh     <= 1'b0;
            lz_sh      <= 1'b0;
            an         <= '1;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            if (slot_end) begin
                presc <= '0;
                idx   <= frame_end ? '0 : idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end

            // all shadowed controls reload together so a frame never mixes old and new
            frame_tick <= frame_end;
            if (frame_end) begin
                value_sh <= value;
                dp_sh    <= dp_in;
                hex_sh   <= hex_mode;
                lz_sh    <= lz_blank;
            end

            if (blank_all) begin
                an  <= '1;
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end else begin
                an  <= an_pat;
                seg <= seg_pat;
                dp  <= guard | ~dp_sh[idx];
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver with 4 digits, 4-cycle slots and a 1-cycle guard.
module tb_seg_scan_driver;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int GD = 1;
    localparam int FRAME = ND * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        hex_mode = 1'b0;
    logic        lz_blank = 1'b0;
    logic        blank_all = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    always #5 clk = ~clk;

    seg_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD(GD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp_in      (dp_in),
        .hex_mode   (hex_mode),
        .lz_blank   (lz_blank),
        .blank_all  (blank_all),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
        logic       chk_seg;
    } exp_t;

    typedef struct {
        logic [15:0]     value;
        logic [3:0]      dp_in;
        logic            hex;
        logic            lz;
        logic [3:0][6:0] segs;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];
    vec_t v1111;
    vec_t v2222;
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input int j, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %0h expected %0h", name, j, act, exp);
    endtask

    task automatic apply(input vec_t v);
        value    = v.value;
        dp_in    = v.dp_in;
        hex_mode = v.hex;
        lz_blank = v.lz;
    endtask

    // one expected record per cycle of the frame that follows a capture
    task automatic push_frame(input vec_t v, input int bl_lo, input int bl_hi);
        for (int j = 0; j < FRAME; j++) begin
            exp_t       e;
            logic [3:0] onehot;
            int         s;
            int         p;
            s = j / RD;
            p = j % RD;
            onehot = 4'b0001 << s;
            if (j >= bl_lo && j <= bl_hi) begin
                e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.chk_seg = 1'b1;
            end else if (p < GD) begin
                e.an = 4'hF; e.seg = 7'h00; e.dp = 1'b1; e.chk_seg = 1'b0;
            end else begin
                e.an = ~onehot; e.seg = v.segs[s]; e.dp = ~v.dp_in[s]; e.chk_seg = 1'b1;
            end
            e.ft = (j == FRAME - 1);
            sb.push_back(e);
        end
    endtask

    task automatic run_frame(input int mid_j, input logic [15:0] mid_val, input int bl_on, input int bl_off);
        for (int j = 0; j < FRAME; j++) begin
            exp_t e;
            @(negedge clk);
            if (sb.size() == 0) begin
                total++;
                $display("FAIL scoreboard_empty[%0d]: got no entry required one", j);
            end else begin
                e = sb.pop_front();
                chk("an", j, 32'(an), 32'(e.an));
                if (e.chk_seg) chk("seg", j, 32'(seg), 32'(e.seg));
                chk("dp", j, 32'(dp), 32'(e.dp));
                chk("frame_tick", j, 32'(frame_tick), 32'(e.ft));
            end
            if (j == mid_j) value = mid_val;
            if (j == bl_on) blank_all = 1'b1;
            if (j == bl_off) blank_all = 1'b0;
        end
    endtask

    task automatic wait_tick(input int gap);
        bit found;
        found = 1'b0;
        for (int k = 1; k <= 3 * FRAME && !found; k++) begin
            @(negedge clk);
            if (frame_tick) begin
                chk("tick_gap", 0, 32'(k), 32'(gap));
                found = 1'b1;
            end
        end
        if (!found) begin
            total++;
            $display("FAIL tick_timeout: got no frame_tick within %0d cycles required %0d", 3 * FRAME, gap);
        end
    endtask

    // releases reset at a falling edge and follows it to the first capture
    task automatic reset_release();
        bit found;
        found = 1'b0;
        rst_n = 1'b1;
        for (int k = 1; k <= 3 * FRAME && !found; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("rel_an", k, 32'(an), 32'h0F);
                chk("rel_dp", k, 32'(dp), 32'h1);
            end
            if (k == 2) begin
                chk("rel_an", k, 32'(an), 32'h0E);
                chk("rel_seg", k, 32'(seg), 32'h40);
                chk("rel_dp", k, 32'(dp), 32'h1);
            end
            if (frame_tick) begin
                chk("first_tick", 0, 32'(k), 32'(FRAME));
                found = 1'b1;
            end
        end
        if (!found) begin
            total++;
            $display("FAIL first_tick_timeout: got no frame_tick required one after %0d cycles", FRAME);
        end
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'b0100, 1'b0, 1'b0, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
        vecs[1] = '{16'h0040, 4'b0000, 1'b0, 1'b1, {7'b1111111, 7'b1111111, 7'b0011001, 7'b1000000}};
        vecs[2] = '{16'h0040, 4'b0000, 1'b0, 1'b0, {7'b1000000, 7'b1000000, 7'b0011001, 7'b1000000}};
        vecs[3] = '{16'hABCD, 4'b0001, 1'b1, 1'b0, {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001}};
        vecs[4] = '{16'hABCD, 4'b0010, 1'b0, 1'b0, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111}};
        vecs[5] = '{16'h00A5, 4'b1111, 1'b0, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010}};
        vecs[6] = '{16'h0000, 4'b1001, 1'b1, 1'b1, {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
        vecs[7] = '{16'h9876, 4'b1000, 1'b0, 1'b1, {7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010}};
        vecs[8] = '{16'hEF00, 4'b0000, 1'b1, 1'b1, {7'b0000110, 7'b0001110, 7'b1000000, 7'b1000000}};
        v1111   = '{16'h1111, 4'b0000, 1'b0, 1'b0, {4{7'b1111001}}};
        v2222   = '{16'h2222, 4'b0000, 1'b0, 1'b0, {4{7'b0100100}}};

        // reset held with random inputs
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            value     = 16'($urandom);
            dp_in     = 4'($urandom);
            hex_mode  = 1'($urandom);
            lz_blank  = 1'($urandom);
            blank_all = 1'($urandom);
            @(negedge clk);
            chk("rst_an", c, 32'(an), 32'h0F);
            chk("rst_seg", c, 32'(seg), 32'h7F);
            chk("rst_dp", c, 32'(dp), 32'h1);
            chk("rst_ft", c, 32'(frame_tick), 32'h0);
        end
        blank_all = 1'b0;
        reset_release();

        for (int i = 0; i < 9; i++) begin
            apply(vecs[i]);
            wait_tick(FRAME);
            push_frame(vecs[i], -1, -1);
            run_frame(-1, 16'h0, -1, -1);
        end

        // value changes while digit 2 is on; the new value only lands at the next capture
        apply(v1111);
        wait_tick(FRAME);
        push_frame(v1111, -1, -1);
        run_frame(2 * RD, 16'h2222, -1, -1);
        push_frame(v2222, -1, -1);
        run_frame(-1, 16'h0, -1, -1);

        // blank_all for 5 cycles mid slot 1; scanning keeps its place
        apply(vecs[0]);
        wait_tick(FRAME);
        push_frame(vecs[0], 6, 10);
        run_frame(-1, 16'h0, 5, 10);

        // reset asserted between clock edges while digit 1 is lit
        apply(vecs[0]);
        wait_tick(FRAME);
        repeat (6) @(negedge clk);
        chk("pre_rst_an", 0, 32'(an), 32'h0D);
        chk("pre_rst_seg", 0, 32'(seg), 32'h30);
        #1 rst_n = 1'b0;
        #1;
        chk("async_an", 0, 32'(an), 32'h0F);
        chk("async_seg", 0, 32'(seg), 32'h7F);
        chk("async_dp", 0, 32'(dp), 32'h1);
        chk("async_ft", 0, 32'(frame_tick), 32'h0);
        repeat (3) @(negedge clk);
        reset_release();
        apply(vecs[3]);
        wait_tick(FRAME);
        push_frame(vecs[3], -1, -1);
        run_frame(-1, 16'h0, -1, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for a bank of common-anode seven-segment digits. It is the parametrised successor of the single-digit decoder. It owns the refresh prescaler, digit scanning, frame-coherent value capture, hex/decimal decoding, leading-zero suppression and anti-ghosting guard time. It sits between the datapath's BCD/hex result registers and the board's segment/anode pins.

## Interface
- NUM_DIGITS, 4: digits in the bank; must be at least 2.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be at least 2.
- GUARD, 4: cycles at the start of each slot with all anodes off; must be less than REFRESH_DIV.
- clk  in  1  system clock, all flops rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- value  in  4*NUM_DIGITS  packed nibbles; value[3:0] is digit 0, the rightmost/least significant.
- dp_in  in  NUM_DIGITS  decimal-point request per digit, 1 = lit.
- hex_mode  in  1  1 = nibbles 10..15 show A b C d E F; 0 = nibbles 10..15 blank.
- lz_blank  in  1  1 = suppress leading zeros.
- blank_all  in  1  1 = whole display dark.
- seg  out  7  segment cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal-point cathode, active-low.
- an  out  NUM_DIGITS  digit anodes, active-low, at most one low at a time.
- frame_tick  out  1  one-cycle pulse when the shadow register reloads.

## Operation
- Prescaler counts 0..REFRESH_DIV-1 and then wraps. The digit index advances on the wrap and runs 0..NUM_DIGITS-1, then back to 0.
- Shadow register: value, dp_in, hex_mode and lz_blank are captured together when the index wraps from NUM_DIGITS-1 to 0, so a frame never tears. frame_tick pulses on the capture cycle. Only blank_all is used live, with no shadowing.
- Digit pattern comes from the shadow nibble of the current index.
  - Decimal digits 0..9 use 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
  - Hex letters A..F use 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
  - Blank is 1111111.
- Leading-zero suppression: digit i (i ≥ 1) is blanked when it and all higher shadow nibbles are zero. Digit 0 is never suppressed.
- dp follows the shadow dp_in of the current digit even when that digit is blanked. It is inactive (1) during guard cycles and under blank_all.
- Guard: while the prescaler is below GUARD, an is all 1s. Otherwise an has a single 0 at the current index.
- blank_all forces an, seg and dp to all 1s. The prescaler and index keep running.

## Timing
- Reset values: prescaler 0, index 0, shadow all 0, an all 1s, seg 1111111, dp 1, frame_tick 0.
- After reset release, the first capture happens after NUM_DIGITS*REFRESH_DIV cycles. Until then the display shows shadow zero; with lz_blank=0 that appears as 0 on every digit.
- All outputs are registered and lag their prescaler/index state by exactly one cycle. The first an low after a slot boundary therefore appears GUARD+1 cycles after the index changes.
- Frame period is NUM_DIGITS*REFRESH_DIV cycles, and frame_tick is spaced exactly that far apart.
- Input changes mid-frame are invisible until the next capture. The exception is blank_all, which takes effect on the next clock edge.
- Reset asserted mid-slot returns every output to its reset value immediately, with no clock needed. Scanning restarts at digit 0.

## Structure
- Package seg_pkg holds:
  - the 7-bit segment constants for 0-9 and A-F,
  - SEG_BLANK = 7'b1111111,
  - the nibble width localparam DIGIT_W = 4.
- Sub-module seg_decoder is combinational. It takes a nibble, hex_mode and blank, and returns the 7-bit pattern. It is instantiated once on the muxed nibble.
- Prescaler width is $clog2(REFRESH_DIV). Index width is $clog2(NUM_DIGITS).

## Test plan
- Reset: hold rst_n low for 3 cycles with random inputs -> an=4'hF, seg=7'h7F, dp=1, frame_tick=0; releasing mid-cycle causes no glitch.
- Scan order, with NUM_DIGITS=4, REFRESH_DIV=4, GUARD=1, value=16'h1234, dp_in=4'b0100 -> frame_tick every 16 cycles. After capture, each slot shows 1 cycle with an=F, then 3 cycles of an=E/seg=0011001, D/0110000, B/0100100 with dp=0, then 7/1111001.
- Leading zeros: value=16'h0040 with lz_blank=1 -> digits 3 and 2 show 1111111, digit 1 shows 0011001, digit 0 shows 1000000. With lz_blank=0, all four digits are lit.
- Hex vs decimal: value=16'hABCD with hex_mode=1 -> digits 0..3 show d, C, b, A. With hex_mode=0 all four show 1111111. value=16'h00A5 in decimal mode -> digit 1 blank, digit 0 shows 0010010.
- Frame coherence: change value from 16'h1111 to 16'h2222 while the index is 2 -> digits 2 and 3 still show 1; digit 0 shows 2 only after frame_tick.
- blank_all mid-slot: assert for 5 cycles -> all outputs 1s on the next edge, index continues. Reset asserted mid-frame -> outputs return to their reset values asynchronously.
